isr: RTL and testbench



---
 rtl/isr_pkg.sv | 14 +
 rtl/isr_step.sv | 26 ++
 rtl/isr.sv | 98 +++++++++
 tb/tb_isr.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/isr_pkg.sv
// Shared widths and state encoding for the isr integer square-root block.
package isr_pkg;

  localparam int IN_W  = 64;
  localparam int OUT_W = IN_W / 2;
  localparam int CNT_W = $clog2(OUT_W);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isr_state_t;

endpackage

// File: rtl/isr_step.sv
// One restoring square-root digit: shift in two operand bits and try to subtract {root,01}.
module isr_step
  import isr_pkg::*;
(
  input  logic [OUT_W+1:0] rem_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [OUT_W+1:0] rem_o,
  output logic [OUT_W-1:0] root_o
);

  logic [OUT_W+1:0] rem_sh;
  logic [OUT_W+1:0] trial;
  logic             ge;

  // The remainder never exceeds OUT_W significant bits before the shift, so
  // dropping its two top bits loses nothing.
  always_comb begin
    rem_sh = {rem_i[OUT_W-1:0], bits_i};
    trial  = {root_i, 2'b01};
    ge     = (rem_sh >= trial);
    rem_o  = ge ? (rem_sh - trial) : rem_sh;
    root_o = {root_i[OUT_W-2:0], ge};
  end

endmodule

// File: rtl/isr.sv
// Multi-cycle floor(sqrt(value)), one result bit per clock; each run is armed by reset.
// Optional ISR_EARLY_DONE_EN finishes operands 0 and 1 directly in the LOAD cycle.
module isr
  import isr_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [IN_W-1:0]   value,
  output logic [OUT_W-1:0]  result,
  output logic              done
);

  isr_state_t         state_q, state_d;
  logic [IN_W-1:0]    operand_q, operand_d;
  logic [OUT_W+1:0]   rem_q, rem_d;
  logic [OUT_W-1:0]   root_q, root_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic [OUT_W+1:0]   step_rem;
  logic [OUT_W-1:0]   step_root;

  isr_step u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .bits_i (operand_q[IN_W-1:IN_W-2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = done_q;
    unique case (state_q)
      LOAD: begin
        operand_d = value;
        rem_d     = '0;
        root_d    = '0;
        cnt_d     = CNT_W'(OUT_W - 1);
        state_d   = CALC;
`ifdef ISR_EARLY_DONE_EN
        if (value < IN_W'(2)) begin
          result_d = {{(OUT_W-1){1'b0}}, value[0]};
          done_d   = 1'b1;
          state_d  = DONE;
        end
`endif
      end
      CALC: begin
        operand_d = operand_q << 2;
        rem_d     = step_rem;
        root_d    = step_root;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          result_d = step_root;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LOAD;
      operand_q <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_isr.sv
// Directed and random checks of the isr square-root block.
module tb_isr;

  logic        clock;
  logic        reset;
  logic [63:0] value;
  logic [31:0] result;
  logic        done;

  int n_cmp;
  int n_err;

  isr dut (
    .clock  (clock),
    .reset  (reset),
    .value  (value),
    .result (result),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent reference: binary search on r*r <= v with wide products.
  function automatic logic [31:0] isqrt_ref(input logic [63:0] v);
    logic [32:0]  lo, hi, mid;
    logic [127:0] sq;
    lo = 33'd0;
    hi = 33'h0_FFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 33'd1) >> 1;
      sq  = 128'(mid) * 128'(mid);
      if (sq <= 128'(v)) lo = mid;
      else hi = mid - 33'd1;
    end
    return lo[31:0];
  endfunction

  task automatic start_op(input logic [63:0] v);
    @(negedge clock);
    reset = 1'b1;
    value = v;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Poll done every 10 cycles, giving up after 100 cycles.
  task automatic wait_done(output logic timed_out);
    int polls;
    polls = 0;
    timed_out = 1'b1;
    while (polls < 10 && timed_out) begin
      repeat (10) @(posedge clock);
      #1;
      if (done === 1'b1) timed_out = 1'b0;
      polls++;
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      value = {$urandom, $urandom};
      @(posedge clock);
      #1;
      n_cmp++;
      if (result !== 32'd0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cycle %0d: result=%h done=%b, required result=0 done=0", i, result, done);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_latency;
    start_op(64'd24);
    repeat (32) @(posedge clock);
    #1;
    n_cmp++;
    if (done !== 1'b0 || result !== 32'd0) begin
      n_err++;
      $display("FAIL latency_pre: after 32 edges done=%b result=%h, required done=0 result=0", done, result);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (done !== 1'b1 || result !== 32'd4) begin
      n_err++;
      $display("FAIL latency_33: done=%b result=%h, required done=1 result=4", done, result);
    end
  endtask

  task automatic test_directed;
    logic [63:0] vecs [6];
    logic [31:0] exps [6];
    logic        to;
    vecs[0] = 64'd24;                 exps[0] = 32'd4;
    vecs[1] = 64'd1001;               exps[1] = 32'd31;
    vecs[2] = 64'd65536;              exps[2] = 32'd256;
    vecs[3] = 64'hFFFF_FFFF_FFFF_FFFF; exps[3] = 32'hFFFF_FFFF;
    vecs[4] = 64'd0;                  exps[4] = 32'd0;
    vecs[5] = 64'd1;                  exps[5] = 32'd1;
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i]);
      wait_done(to);
      n_cmp++;
      if (to || result !== exps[i]) begin
        n_err++;
        $display("FAIL directed value=%h: result=%h timeout=%b, required %h", vecs[i], result, to, exps[i]);
      end
    end
  endtask

  task automatic test_abort;
    logic to;
    start_op(64'd1001);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (done !== 1'b0 || result !== 32'd0) begin
      n_err++;
      $display("FAIL abort_reset: done=%b result=%h, required done=0 result=0", done, result);
    end
    @(negedge clock);
    value = 64'd24;
    reset = 1'b0;
    wait_done(to);
    n_cmp++;
    if (to || result !== 32'd4) begin
      n_err++;
      $display("FAIL abort_rerun: result=%h timeout=%b, required 4", result, to);
    end
  endtask

  task automatic test_value_change;
    logic [31:0] held;
    start_op(64'd65536);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      value = {$urandom, $urandom};
    end
    #1;
    n_cmp++;
    if (done !== 1'b1 || result !== 32'd256) begin
      n_err++;
      $display("FAIL value_change: done=%b result=%h, required done=1 result=256", done, result);
    end
    held = 32'd256;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      value = {$urandom, $urandom};
      @(posedge clock);
      #1;
      n_cmp++;
      if (done !== 1'b1 || result !== held) begin
        n_err++;
        $display("FAIL done_sticky cycle %0d: done=%b result=%h, required done=1 result=%h", i, done, result, held);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0]  v;
    logic [31:0]  r;
    logic [127:0] lo_sq, hi_sq;
    logic         to;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) v = {32'd0, $urandom};
      else v = {$urandom, $urandom};
      r = isqrt_ref(v);
      start_op(v);
      wait_done(to);
      lo_sq = 128'(result) * 128'(result);
      hi_sq = (128'(result) + 128'd1) * (128'(result) + 128'd1);
      n_cmp++;
      if (to || result !== r || lo_sq > 128'(v) || hi_sq <= 128'(v)) begin
        n_err++;
        $display("FAIL random value=%h: result=%h timeout=%b, required %h", v, result, to, r);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    value = 64'd0;
    test_reset;
    test_latency;
    test_directed;
    test_abort;
    test_value_change;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
